// File: rtl/disp_chars_pkg.sv
// Character codes, BCD markers and shared enums for the display/entry path.
// Shared by disp2bcd_entry and bcd2disp so both sides agree on the encoding.
package disp_chars_pkg;

  localparam logic [7:0] CHAR_0            = 8'h30;
  localparam logic [7:0] CHAR_1            = 8'h31;
  localparam logic [7:0] CHAR_2            = 8'h32;
  localparam logic [7:0] CHAR_3            = 8'h33;
  localparam logic [7:0] CHAR_4            = 8'h34;
  localparam logic [7:0] CHAR_5            = 8'h35;
  localparam logic [7:0] CHAR_6            = 8'h36;
  localparam logic [7:0] CHAR_7            = 8'h37;
  localparam logic [7:0] CHAR_8            = 8'h38;
  localparam logic [7:0] CHAR_9            = 8'h39;
  localparam logic [7:0] CHAR_BLANK        = 8'h20;
  localparam logic [7:0] CHAR_PERIOD       = 8'h2E;
  localparam logic [7:0] CHAR_HYPHEN_MINUS = 8'h2D;
  localparam logic [7:0] CHAR_ASTERISK     = 8'h2A;
  localparam logic [7:0] CHAR_CR           = 8'h0D;
  localparam logic [7:0] CHAR_BACKSPACE    = 8'h08;
  localparam logic [7:0] CHAR_ESC          = 8'h1B;

  localparam logic [3:0] BCD_PERIOD = 4'hF;

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    ERROR = 2'd1,
    DONE  = 2'd2
  } entry_state_t;

  typedef enum logic [2:0] {
    CC_DIGIT     = 3'd0,
    CC_PERIOD    = 3'd1,
    CC_MINUS     = 3'd2,
    CC_BLANK     = 3'd3,
    CC_BACKSPACE = 3'd4,
    CC_ESC       = 3'd5,
    CC_CR        = 3'd6,
    CC_OTHER     = 3'd7
  } char_class_t;

endpackage

// File: rtl/char_classify.sv
// Combinational character decoder: maps a character code to its class and,
// for decimal digits, the BCD value.
module char_classify
  import disp_chars_pkg::*;
(
  input  logic [7:0]  char_in,
  output char_class_t char_class,
  output logic [3:0]  digit
);

  // Digits '0'..'9' carry their value in the low nibble of the code
  always_comb begin
    char_class = CC_OTHER;
    digit      = 4'h0;
    if ((char_in >= CHAR_0) && (char_in <= CHAR_9)) begin
      char_class = CC_DIGIT;
      digit      = char_in[3:0];
    end else begin
      case (char_in)
        CHAR_PERIOD:       char_class = CC_PERIOD;
        CHAR_HYPHEN_MINUS: char_class = CC_MINUS;
        CHAR_BLANK:        char_class = CC_BLANK;
        CHAR_BACKSPACE:    char_class = CC_BACKSPACE;
        CHAR_ESC:          char_class = CC_ESC;
        CHAR_CR:           char_class = CC_CR;
        default:           char_class = CC_OTHER;
      endcase
    end
  end

endmodule

// File: rtl/disp2bcd_entry.sv
// Serial character-entry parser building a sign + right-aligned BCD value;
// a carriage return commits it through a valid/ready output handshake.
module disp2bcd_entry
  import disp_chars_pkg::*;
#(
  parameter int DIGITS    = 10,
  parameter bit ALLOW_DOT = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [7:0]                   char_in,
  input  logic                         char_valid,
  output logic                         char_ready,
  output logic                         sign,
  output logic [4*DIGITS-1:0]          bcd,
  output logic [$clog2(DIGITS+1)-1:0]  n_digits,
  output logic                         out_valid,
  output logic                         out_err,
  input  logic                         out_ready
);

  localparam int NW = $clog2(DIGITS + 1);
  localparam int BW = 4 * DIGITS;
  localparam logic [NW-1:0] N_MAX  = NW'(DIGITS);
  localparam logic [NW-1:0] N_ONE  = NW'(1);
  localparam logic [NW-1:0] N_ZERO = NW'(0);

  entry_state_t    state_q, state_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            sign_q, sign_d;
  logic [NW-1:0]   n_q, n_d;
  logic            dot_q, dot_d;
  logic            out_valid_q, out_valid_d;
  logic            out_err_q, out_err_d;
  logic            char_ready_q, char_ready_d;

  char_class_t     cls_s;
  logic [3:0]      digit_s;
  logic            char_xfer_s;
  logic            has_room_s;
  logic            empty_s;
  logic            lead_zero_s;

  char_classify u_classify (
    .char_in    (char_in),
    .char_class (cls_s),
    .digit      (digit_s)
  );

  assign char_ready = char_ready_q;
  assign sign       = sign_q;
  assign bcd        = bcd_q;
  assign n_digits   = n_q;
  assign out_valid  = out_valid_q;
  assign out_err    = out_err_q;

  // Next-state and datapath update for one accepted character or commit
  always_comb begin
    state_d     = state_q;
    bcd_d       = bcd_q;
    sign_d      = sign_q;
    n_d         = n_q;
    dot_d       = dot_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    char_xfer_s = char_valid & char_ready_q;
    has_room_s  = (n_q < N_MAX);
    empty_s     = (n_q == N_ZERO);
    // A zero typed into an empty, unsigned value adds nothing to it
    lead_zero_s = empty_s & ~sign_q & ~dot_q & (digit_s == 4'h0);

    case (state_q)
      ENTRY: begin
        if (char_xfer_s) begin
          case (cls_s)
            CC_DIGIT: begin
              if (!has_room_s) begin
                state_d = ERROR;
              end else if (lead_zero_s) begin
                n_d = n_q;
              end else begin
                bcd_d = {bcd_q[BW-5:0], digit_s};
                n_d   = n_q + N_ONE;
              end
            end
            CC_PERIOD: begin
              if (ALLOW_DOT && !dot_q && has_room_s) begin
                bcd_d = {bcd_q[BW-5:0], BCD_PERIOD};
                n_d   = n_q + N_ONE;
                dot_d = 1'b1;
              end else begin
                state_d = ERROR;
              end
            end
            CC_MINUS: begin
              if (empty_s && !sign_q) begin
                sign_d = 1'b1;
              end else begin
                state_d = ERROR;
              end
            end
            CC_BLANK: state_d = ENTRY;
            CC_BACKSPACE: begin
              // With no digits left, backspace removes the sign instead
              if (!empty_s) begin
                bcd_d = {4'h0, bcd_q[BW-1:4]};
                n_d   = n_q - N_ONE;
                if (bcd_q[3:0] == BCD_PERIOD) begin
                  dot_d = 1'b0;
                end else begin
                  dot_d = dot_q;
                end
              end else begin
                sign_d = 1'b0;
              end
            end
            CC_ESC: begin
              bcd_d  = {BW{1'b0}};
              sign_d = 1'b0;
              n_d    = N_ZERO;
              dot_d  = 1'b0;
            end
            CC_CR: begin
              if (empty_s) begin
                sign_d = 1'b0;
              end else begin
                sign_d = sign_q;
              end
              state_d     = DONE;
              out_valid_d = 1'b1;
              out_err_d   = 1'b0;
            end
            default: state_d = ERROR;
          endcase
        end else begin
          state_d = ENTRY;
        end
      end

      ERROR: begin
        if (char_xfer_s && (cls_s == CC_CR)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
        end else if (char_xfer_s && (cls_s == CC_ESC)) begin
          state_d = ENTRY;
          bcd_d   = {BW{1'b0}};
          sign_d  = 1'b0;
          n_d     = N_ZERO;
          dot_d   = 1'b0;
        end else begin
          state_d = ERROR;
        end
      end

      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d     = ENTRY;
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          bcd_d       = {BW{1'b0}};
          sign_d      = 1'b0;
          n_d         = N_ZERO;
          dot_d       = 1'b0;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d     = ENTRY;
        out_valid_d = 1'b0;
        out_err_d   = 1'b0;
      end
    endcase

    char_ready_d = (state_d != DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ENTRY;
      bcd_q        <= {BW{1'b0}};
      sign_q       <= 1'b0;
      n_q          <= N_ZERO;
      dot_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_err_q    <= 1'b0;
      char_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      bcd_q        <= bcd_d;
      sign_q       <= sign_d;
      n_q          <= n_d;
      dot_q        <= dot_d;
      out_valid_q  <= out_valid_d;
      out_err_q    <= out_err_d;
      char_ready_q <= char_ready_d;
    end
  end

endmodule

// File: tb/tb_disp2bcd_entry.sv
// Scoreboard bench for disp2bcd_entry: a queue-based reference model predicts the
// live value after every handshake; a monitor compares whenever the DUT updates.
module tb_disp2bcd_entry;
  import disp_chars_pkg::*;

  localparam int DIGITS = 10;
  localparam int NW     = $clog2(DIGITS + 1);
  localparam int BW     = 4 * DIGITS;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [7:0]    char_in = 8'h00;
  logic          char_valid = 1'b0;
  logic          char_ready;
  logic          sign;
  logic [BW-1:0] bcd;
  logic [NW-1:0] n_digits;
  logic          out_valid;
  logic          out_err;
  logic          out_ready = 1'b0;

  logic [7:0]    c2_in = 8'h00;
  logic          c2_valid = 1'b0;
  logic          c2_ready;
  logic          c2_sign;
  logic [BW-1:0] c2_bcd;
  logic [NW-1:0] c2_n;
  logic          c2_ov;
  logic          c2_oe;
  logic          c2_or = 1'b0;

  always #5 clk = ~clk;

  disp2bcd_entry #(.DIGITS(DIGITS), .ALLOW_DOT(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .char_in(char_in), .char_valid(char_valid),
    .char_ready(char_ready), .sign(sign), .bcd(bcd), .n_digits(n_digits),
    .out_valid(out_valid), .out_err(out_err), .out_ready(out_ready)
  );

  disp2bcd_entry #(.DIGITS(DIGITS), .ALLOW_DOT(1'b0)) dut_nodot (
    .clk(clk), .reset_n(reset_n), .char_in(c2_in), .char_valid(c2_valid),
    .char_ready(c2_ready), .sign(c2_sign), .bcd(c2_bcd), .n_digits(c2_n),
    .out_valid(c2_ov), .out_err(c2_oe), .out_ready(c2_or)
  );

  typedef struct packed {
    logic          sign;
    logic [BW-1:0] bcd;
    logic [NW-1:0] n;
    logic          ov;
    logic          oe;
  } snap_t;

  // Reference model: typed positions in order, 15 standing for the period
  int    m_digs[$];
  bit    m_sign, m_bad, m_done, m_err;
  snap_t exp_q[$];
  snap_t commit_q[$];
  int    n_pass = 0;
  int    n_total = 0;
  logic  pend = 1'b0;
  logic  commit_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic void model_clear();
    m_digs.delete();
    m_sign = 1'b0; m_bad = 1'b0; m_done = 1'b0; m_err = 1'b0;
  endfunction

  function automatic bit model_has_dot();
    foreach (m_digs[i]) if (m_digs[i] == 15) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [BW-1:0] model_bcd();
    logic [BW-1:0] r = '0;
    for (int i = 0; i < m_digs.size(); i++) r[4*(m_digs.size()-1-i) +: 4] = 4'(m_digs[i]);
    return r;
  endfunction

  function automatic snap_t snap();
    snap_t s;
    s.sign = m_sign; s.bcd = model_bcd(); s.n = NW'(m_digs.size());
    s.ov = m_done; s.oe = m_done && m_err;
    return s;
  endfunction

  function automatic void model_apply(input logic [7:0] c);
    if (m_bad) begin
      if (c == CHAR_CR) begin m_done = 1'b1; m_err = 1'b1; end
      else if (c == CHAR_ESC) model_clear();
      return;
    end
    if (c >= CHAR_0 && c <= CHAR_9) begin
      int d;
      d = int'(c) - int'(CHAR_0);
      if (m_digs.size() >= DIGITS) m_bad = 1'b1;
      else if (!(m_digs.size() == 0 && !m_sign && d == 0)) m_digs.push_back(d);
      return;
    end
    case (c)
      CHAR_PERIOD:
        if (!model_has_dot() && m_digs.size() < DIGITS) m_digs.push_back(15);
        else m_bad = 1'b1;
      CHAR_HYPHEN_MINUS:
        if (m_digs.size() == 0 && !m_sign) m_sign = 1'b1;
        else m_bad = 1'b1;
      CHAR_BLANK: ;
      CHAR_BACKSPACE:
        if (m_digs.size() > 0) void'(m_digs.pop_back());
        else m_sign = 1'b0;
      CHAR_ESC: model_clear();
      CHAR_CR: begin
        if (m_digs.size() == 0) m_sign = 1'b0;
        m_done = 1'b1; m_err = 1'b0;
      end
      default: m_bad = 1'b1;
    endcase
  endfunction

  task automatic compare_snap(input snap_t e);
    check("live_sign", sign, e.sign);
    check("live_bcd", bcd, e.bcd);
    check("live_n_digits", n_digits, e.n);
    check("live_out_valid", out_valid, e.ov);
    check("live_out_err", out_err, e.oe);
  endtask

  task automatic compare_commit(input snap_t e);
    check("commit_sign", sign, e.sign);
    check("commit_bcd", bcd, e.bcd);
    check("commit_out_err", out_err, e.oe);
  endtask

  // Monitor: note a handshake at the edge, compare against the scoreboard half a cycle later
  always @(posedge clk) pend <= (char_valid && char_ready) || (out_valid && out_ready);

  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_update: DUT updated with no prediction queued at %0t", $time);
      end else compare_snap(exp_q.pop_front());
    end
    if (out_valid && !commit_seen) begin
      if (commit_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_commit: out_valid rose with no commit predicted at %0t", $time);
      end else compare_commit(commit_q.pop_front());
    end
    commit_seen <= out_valid;
  end

  task automatic send(input logic [7:0] c);
    int b = 0;
    char_in = c; char_valid = 1'b1;
    while (!char_ready && b < 20) begin @(negedge clk); b++; end
    if (!char_ready) begin
      n_total++;
      $display("FAIL char_ready_timeout: char %0h never accepted", c);
      char_valid = 1'b0;
      return;
    end
    model_apply(c);
    exp_q.push_back(snap());
    if (m_done) commit_q.push_back(snap());
    @(negedge clk);
    char_valid = 1'b0;
  endtask

  task automatic release_out(input int hold);
    int b = 0;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    while (!out_valid && b < 20) begin @(negedge clk); b++; end
    if (!out_valid) begin
      n_total++;
      $display("FAIL out_valid_timeout: committed value never presented");
      out_ready = 1'b0;
      model_clear();
      return;
    end
    model_clear();
    exp_q.push_back(snap());
    @(negedge clk);
    out_ready = 1'b0;
    check("ready_after_commit", char_ready, 1'b1);
  endtask

  function automatic logic [7:0] rand_char();
    int r;
    r = $urandom_range(0, 99);
    if (r < 55) return 8'(int'(CHAR_0) + $urandom_range(0, 9));
    if (r < 62) return CHAR_PERIOD;
    if (r < 66) return CHAR_HYPHEN_MINUS;
    if (r < 70) return CHAR_BLANK;
    if (r < 78) return CHAR_BACKSPACE;
    if (r < 81) return CHAR_ESC;
    if (r < 90) return CHAR_CR;
    if (r < 93) return CHAR_ASTERISK;
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    check("reset_bcd", bcd, '0);
    check("reset_sign", sign, 1'b0);
    check("reset_n_digits", n_digits, '0);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_err", out_err, 1'b0);
    check("reset_char_ready", char_ready, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);

    // Signed value with a period
    send(CHAR_HYPHEN_MINUS); send(CHAR_1); send(CHAR_2); send(CHAR_PERIOD); send(CHAR_5);
    send(CHAR_CR);
    check("t1_sign", sign, 1'b1);
    check("t1_bcd", bcd[15:0], 16'h12F5);
    check("t1_n_digits", n_digits, 4'd4);
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_out_err", out_err, 1'b0);
    release_out(1);

    // Overflow freezes the value and commits with an error
    repeat (10) send(CHAR_9);
    send(CHAR_9);
    check("t2_bcd_frozen", bcd, {DIGITS{4'h9}});
    check("t2_n_digits", n_digits, 4'd10);
    send(CHAR_CR);
    check("t2_out_err", out_err, 1'b1);
    release_out(0);

    // Leading zeros and backspace
    send(CHAR_0); send(CHAR_0); send(CHAR_7); send(CHAR_BACKSPACE); send(CHAR_3);
    send(CHAR_CR);
    check("t3_bcd", bcd, 40'h3);
    check("t3_n_digits", n_digits, 4'd1);
    release_out(0);
    send(CHAR_BACKSPACE);
    check("t3_bs_empty_n", n_digits, 4'd0);
    check("t3_bs_empty_bcd", bcd, '0);

    // Misplaced minus, double period, recovery by ESC
    send(CHAR_5); send(CHAR_HYPHEN_MINUS); send(CHAR_7);
    check("t4_minus_err_n", n_digits, 4'd1);
    send(CHAR_ESC);
    send(CHAR_1); send(CHAR_PERIOD); send(CHAR_PERIOD);
    check("t4_dot_err_bcd", bcd[7:0], 8'h1F);
    send(CHAR_ESC);
    check("t4_esc_bcd", bcd, '0);
    check("t4_esc_sign", sign, 1'b0);

    // Period rejected when dots are disabled
    c2_in = CHAR_3; c2_valid = 1'b1;
    @(negedge clk); c2_in = CHAR_PERIOD;
    @(negedge clk); c2_in = CHAR_CR;
    @(negedge clk); c2_valid = 1'b0;
    check("nodot_n_digits", c2_n, 4'd1);
    check("nodot_bcd", c2_bcd, 40'h3);
    check("nodot_out_valid", c2_ov, 1'b1);
    check("nodot_out_err", c2_oe, 1'b1);
    c2_or = 1'b1;
    @(negedge clk); c2_or = 1'b0;
    check("nodot_released", c2_ov, 1'b0);

    // DONE holds against incoming characters until the consumer takes it
    send(CHAR_8); send(CHAR_CR);
    char_in = CHAR_1; char_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_char_ready", char_ready, 1'b0);
      check("t5_bcd_stable", bcd, model_bcd());
      check("t5_out_valid", out_valid, 1'b1);
    end
    char_valid = 1'b0;
    release_out(0);

    // Asynchronous reset mid-entry
    send(CHAR_4); send(CHAR_2);
    #2 reset_n = 1'b0;
    #1;
    check("t6_bcd", bcd, '0);
    check("t6_n_digits", n_digits, '0);
    check("t6_out_valid", out_valid, 1'b0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (m_done) release_out($urandom_range(0, 3));
      else begin
        if ($urandom_range(0, 7) == 0) begin
          out_ready = 1'b1; @(negedge clk); out_ready = 1'b0;
        end
        send(rand_char());
      end
    end
    if (m_done) release_out(0);
    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("commits_drained", commit_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
